button_debounce_bank: RTL and testbench

BUTTON_DEBOUNCE_BANK -- requirements
Module: button_debounce_bank

---
 rtl/button_pkg.sv | 18 +
 rtl/debounce_chan.sv | 108 ++++++++++
 rtl/button_debounce_bank.sv | 60 ++++++
 tb/tb_button_debounce_bank.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the button debounce bank.
package button_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } chan_state_t;

    localparam int HOLD_W = 16;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced button channel: synchronizer, debounce FSM, stable and hold timers.
//   state           | meaning
//   ST_RELEASED     | accepted level 0, input agrees
//   ST_PRESS_WAIT   | input high, counting agreeing ticks before accepting the press
//   ST_HELD         | accepted level 1, hold timer running toward auto-repeat
//   ST_RELEASE_WAIT | input low, counting agreeing ticks; hold timer frozen
module debounce_chan
    import button_pkg::*;
#(
    parameter int STABLE       = 10,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10,
    parameter int REPEAT_EN    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic button_in,
    output logic db_level,
    output logic press_p,
    output logic release_p,
    output logic repeat_p
);

    localparam int SW = cnt_w(STABLE);

    logic              sync_1;
    logic              s;
    chan_state_t       state;
    logic [SW-1:0]     stab_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1    <= 1'b0;
            s         <= 1'b0;
            state     <= ST_RELEASED;
            stab_cnt  <= '0;
            hold_cnt  <= '0;
            db_level  <= 1'b0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            repeat_p  <= 1'b0;
        end else begin
            sync_1    <= button_in;
            s         <= sync_1;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            repeat_p  <= 1'b0;

            // Hold timer counts down; terminal count fires a repeat and reloads the repeat interval.
            if (state == ST_HELD && tick) begin
                if (hold_cnt <= HOLD_W'(1)) begin
                    repeat_p <= (REPEAT_EN != 0);
                    hold_cnt <= HOLD_W'(REPEAT_TICKS);
                end else begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                end
            end

            case (state)
                ST_RELEASED: begin
                    if (s) begin
                        state    <= ST_PRESS_WAIT;
                        stab_cnt <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state    <= ST_RELEASED;
                        stab_cnt <= '0;
                    end else if (tick) begin
                        if (stab_cnt == SW'(STABLE - 1)) begin
                            state    <= ST_HELD;
                            press_p  <= 1'b1;
                            db_level <= 1'b1;
                            hold_cnt <= HOLD_W'(HOLD_TICKS);
                        end else begin
                            stab_cnt <= stab_cnt + SW'(1);
                        end
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state    <= ST_RELEASE_WAIT;
                        stab_cnt <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s) begin
                        state <= ST_HELD;
                    end else if (tick) begin
                        if (stab_cnt == SW'(STABLE - 1)) begin
                            state     <= ST_RELEASED;
                            release_p <= 1'b1;
                            db_level  <= 1'b0;
                            hold_cnt  <= '0;
                        end else begin
                            stab_cnt <= stab_cnt + SW'(1);
                        end
                    end
                end
                default: state <= ST_RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of independent debounced buttons sharing one sample-tick prescaler.
module button_debounce_bank
    import button_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int STABLE       = 10,
    parameter int TICK_DIV     = 1,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10,
    parameter int REPEAT_EN    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] press_p,
    output logic [N_CH-1:0] release_p,
    output logic [N_CH-1:0] repeat_p
);

    logic tick;

    generate
        if (TICK_DIV == 1) begin : g_no_div
            assign tick = 1'b1;
        end else begin : g_div
            localparam int PW = cnt_w(TICK_DIV - 1);
            logic [PW-1:0] pre_cnt;

            always_ff @(posedge clk) begin
                if (rst || pre_cnt == PW'(TICK_DIV - 1)) begin
                    pre_cnt <= '0;
                end else begin
                    pre_cnt <= pre_cnt + PW'(1);
                end
            end

            assign tick = (pre_cnt == PW'(TICK_DIV - 1));
        end
    endgenerate

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .STABLE       (STABLE),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS),
            .REPEAT_EN    (REPEAT_EN)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .button_in (button_in[i]),
            .db_level  (db_level[i]),
            .press_p   (press_p[i]),
            .release_p (release_p[i]),
            .repeat_p  (repeat_p[i])
        );
    end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed and randomized checks of two debounce banks (tick every clk and every 5 clks).
module tb_button_debounce_bank;

    localparam int NC = 4;
    localparam int ST = 4;
    localparam int HT = 8;
    localparam int RT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] button_in = '0;
    logic [NC-1:0] db1, pr1, rl1, rp1;
    logic [NC-1:0] db5, pr5, rl5, rp5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_debounce_bank #(
        .N_CH(NC), .STABLE(ST), .TICK_DIV(1), .HOLD_TICKS(HT), .REPEAT_TICKS(RT), .REPEAT_EN(1)
    ) dut1 (
        .clk(clk), .rst(rst), .button_in(button_in),
        .db_level(db1), .press_p(pr1), .release_p(rl1), .repeat_p(rp1)
    );

    button_debounce_bank #(
        .N_CH(NC), .STABLE(ST), .TICK_DIV(5), .HOLD_TICKS(HT), .REPEAT_TICKS(RT), .REPEAT_EN(1)
    ) dut5 (
        .clk(clk), .rst(rst), .button_in(button_in),
        .db_level(db5), .press_p(pr5), .release_p(rl5), .repeat_p(rp5)
    );

    // Reference model: accepted level, pending-change flag, agreeing-tick run length,
    // absolute hold ticks since press and the hold tick at which the next repeat is due.
    int       pc [2];
    bit       m_s1 [2][NC];
    bit       m_s  [2][NC];
    bit       m_db [2][NC];
    bit       m_pend [2][NC];
    int       m_run [2][NC];
    int       m_hold [2][NC];
    int       m_next [2][NC];
    logic [NC-1:0] e_db [2];
    logic [NC-1:0] e_pr [2];
    logic [NC-1:0] e_rl [2];
    logic [NC-1:0] e_rp [2];

    function automatic void model_edge(input int d, input int div);
        bit tick;
        bit held;
        e_pr[d] = '0;
        e_rl[d] = '0;
        e_rp[d] = '0;
        if (rst) begin
            pc[d] = 0;
            for (int c = 0; c < NC; c++) begin
                m_s1[d][c] = 0; m_s[d][c] = 0; m_db[d][c] = 0; m_pend[d][c] = 0;
                m_run[d][c] = 0; m_hold[d][c] = 0; m_next[d][c] = HT;
            end
            e_db[d] = '0;
            return;
        end
        tick  = (pc[d] == div - 1);
        pc[d] = tick ? 0 : pc[d] + 1;
        for (int c = 0; c < NC; c++) begin
            held = m_db[d][c] && !m_pend[d][c];
            if (held && tick) begin
                m_hold[d][c]++;
                if (m_hold[d][c] == m_next[d][c]) begin
                    e_rp[d][c]   = 1'b1;
                    m_next[d][c] = m_next[d][c] + RT;
                end
            end
            if (!m_pend[d][c]) begin
                if (m_s[d][c] != m_db[d][c]) begin
                    m_pend[d][c] = 1;
                    m_run[d][c]  = 0;
                end
            end else if (m_s[d][c] == m_db[d][c]) begin
                m_pend[d][c] = 0;
            end else if (tick) begin
                m_run[d][c]++;
                if (m_run[d][c] == ST) begin
                    m_db[d][c]   = m_s[d][c];
                    m_pend[d][c] = 0;
                    if (m_s[d][c]) begin
                        e_pr[d][c]   = 1'b1;
                        m_hold[d][c] = 0;
                        m_next[d][c] = HT;
                    end else begin
                        e_rl[d][c] = 1'b1;
                    end
                end
            end
            m_s[d][c]  = m_s1[d][c];
            m_s1[d][c] = button_in[c];
            e_db[d][c] = m_db[d][c];
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(0, 1);
        model_edge(1, 5);
        @(negedge clk);
        chk("d1_db_level",  32'(db1), 32'(e_db[0]));
        chk("d1_press_p",   32'(pr1), 32'(e_pr[0]));
        chk("d1_release_p", 32'(rl1), 32'(e_rl[0]));
        chk("d1_repeat_p",  32'(rp1), 32'(e_rp[0]));
        chk("d5_db_level",  32'(db5), 32'(e_db[1]));
        chk("d5_press_p",   32'(pr5), 32'(e_pr[1]));
        chk("d5_release_p", 32'(rl5), 32'(e_rl[1]));
        chk("d5_repeat_p",  32'(rp5), 32'(e_rp[1]));
    endtask

    initial begin
        int pe1, pe5, pe, npulse, nrel, nrep, other;
        logic [NC-1:0] pv;
        int rep_q[$];

        rst = 1'b1;
        button_in = '0;
        cyc();
        cyc();
        chk("reset_outputs", 32'({db1, pr1, rl1, rp1, db5, pr5, rl5, rp5}), 32'd0);
        rst = 1'b0;

        // Clean press on ch0; both banks.
        button_in[0] = 1'b1;
        pe1 = -1; pe5 = -1; other = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (pr1[0] && pe1 < 0) pe1 = k;
            if (pr5[0] && pe5 < 0) pe5 = k;
            if ((pr1[3:1] | rl1 | rp1[3:1] | db1[3:1]) != 0) other++;
        end
        chk("ch0_press_edge", pe1, 6);
        chk("ch0_db_level", 32'(db1), 32'h1);
        chk("ch0_others_quiet", other, 0);
        chk("div5_press_window", 32'(pe5 >= 18 && pe5 <= 22), 32'd1);

        // Bounce on ch1, then stable high.
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            button_in[1] = (i % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                cyc();
                if (pr1[1] || rl1[1] || rp1[1]) npulse++;
            end
        end
        button_in[1] = 1'b1;
        pe = -1; pv = '0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (pr1[1]) begin
                if (pe < 0) pe = k;
                pv = pv + 1'b1;
            end
        end
        chk("bounce_no_pulse", npulse, 0);
        chk("bounce_press_edge", pe, 6);
        chk("bounce_press_count", 32'(pv), 32'd1);

        // ch2 held: repeat schedule relative to the press edge.
        button_in[2] = 1'b1;
        pe = -1;
        rep_q.delete();
        for (int k = 0; k < 37; k++) begin
            cyc();
            if (pr1[2]) pe = k;
            if (rp1[2] && pe >= 0) rep_q.push_back(k - pe);
        end
        chk("repeat_count", rep_q.size(), 8);
        foreach (rep_q[i]) chk("repeat_offset", rep_q[i], HT + RT * i);

        // Short low glitch on ch2: no release, repeats continue.
        button_in[2] = 1'b0;
        cyc();
        cyc();
        button_in[2] = 1'b1;
        nrel = 0; nrep = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (rl1[2]) nrel++;
            if (rp1[2]) nrep++;
        end
        chk("glitch_no_release", nrel, 0);
        chk("glitch_repeat_continues", 32'(nrep > 0), 32'd1);
        chk("glitch_db_level", 32'(db1[2]), 32'd1);

        // Release everything, then press ch0 and ch3 together.
        button_in = '0;
        for (int k = 0; k < 30; k++) cyc();
        button_in = 4'b1001;
        pe = -1; pv = '0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (pr1 != 0 && pe < 0) begin
                pe = k;
                pv = pr1;
            end
        end
        chk("dual_press_vec", 32'(pv), 32'h9);
        chk("dual_press_edge", pe, 6);

        // Reset during PRESS_WAIT on ch1 with the button still high.
        button_in = '0;
        for (int k = 0; k < 30; k++) cyc();
        button_in[1] = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        rst = 1'b1;
        npulse = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if ((pr1 | rl1 | rp1 | pr5 | rl5 | rp5) != 0) npulse++;
        end
        chk("rst_no_pulse", npulse, 0);
        chk("rst_db_cleared", 32'({db1, db5}), 32'd0);
        rst = 1'b0;
        pe = -1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (pr1[1] && pe < 0) pe = k;
        end
        chk("post_rst_press_edge", pe, 6);

        // Randomized traffic against the model, fast then slow toggling, rare resets.
        for (int k = 0; k < 2000; k++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, (k < 1000) ? 11 : 39) == 0) button_in[c] = ~button_in[c];
            end
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
